// File: rtl/fb_swap_pattern_ctrl_if.sv
// Bundle of the pattern controller's button, vsync, BRAM-write and status signals.
// master = controller side, slave = the surrounding VGA/BRAM/button logic.
interface fb_swap_pattern_ctrl_if #(
  parameter int WIDTH       = 4,
  parameter int ADDR_LEN    = 17,
  parameter int NUM_BUFFERS = 2
);
  localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;

  logic                swap_btn_in;
  logic                frame_start_in;
  logic                write_enable_out;
  logic [ADDR_LEN-1:0] write_addr_out;
  logic [WIDTH-1:0]    write_data_out;
  logic                swap_buffers_out;
  logic [IDX_W-1:0]    front_idx_out;
  logic [IDX_W-1:0]    back_idx_out;
  logic [1:0]          pattern_out;
  logic                fill_busy_out;
  logic                heartbeat_out;

  modport master (
    input  swap_btn_in, frame_start_in,
    output write_enable_out, write_addr_out, write_data_out, swap_buffers_out,
    output front_idx_out, back_idx_out, pattern_out, fill_busy_out, heartbeat_out
  );

  modport slave (
    output swap_btn_in, frame_start_in,
    input  write_enable_out, write_addr_out, write_data_out, swap_buffers_out,
    input  front_idx_out, back_idx_out, pattern_out, fill_busy_out, heartbeat_out
  );
endinterface

// File: rtl/fb_swap_pattern_ctrl.sv
// N-buffer framebuffer controller: fills the back buffer with a test pattern, queues one
// debounced swap request and swaps front/back only on a frame_start pulse.
module fb_swap_pattern_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DISPLAY_WIDTH   = 320,
  parameter int DISPLAY_HEIGHT  = 240,
  parameter int ADDR_LEN        = 17,
  parameter int NUM_BUFFERS     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HEARTBEAT_BITS  = 23
) (
  input logic                   clk,
  input logic                   rst_n,
  fb_swap_pattern_ctrl_if.master bus
);
  localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam int XW0   = $clog2(DISPLAY_WIDTH);
  localparam int YW0   = $clog2(DISPLAY_HEIGHT);
  localparam int CW_A  = (XW0 > YW0) ? XW0 : YW0;
  localparam int CW_B  = (WIDTH > 4) ? WIDTH : 4;
  localparam int CW    = (CW_A > CW_B) ? CW_A : CW_B;
  localparam int DBW   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0]    X_LAST  = CW'(DISPLAY_WIDTH - 1);
  localparam logic [CW-1:0]    Y_LAST  = CW'(DISPLAY_HEIGHT - 1);
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] B_LAST  = IDX_W'(NUM_BUFFERS - 1);

  typedef enum logic [1:0] {S_FILL, S_READY, S_WAIT} state_t;

  function automatic logic [WIDTH-1:0] pattern_pix(input logic [1:0] sel,
                                                   input logic [WIDTH-1:0] xs,
                                                   input logic [WIDTH-1:0] ys,
                                                   input logic x3, input logic y3);
    case (sel)
      2'd0:    return xs;
      2'd1:    return ys;
      2'd2:    return {WIDTH{x3 ^ y3}};
      default: return xs + ys;
    endcase
  endfunction

  // Reset asserts asynchronously, releases two clocks later.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // ---- stage p0: button synchroniser/debounce, FSM and fill counters ----
  logic           btn_s1_p0, btn_s2_p0, btn_db_p0;
  logic [DBW-1:0] db_cnt_p0;
  logic           db_rise;

  assign db_rise = btn_s2_p0 && !btn_db_p0 && (db_cnt_p0 == DB_LAST);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_s1_p0 <= 1'b0;
      btn_s2_p0 <= 1'b0;
      btn_db_p0 <= 1'b0;
      db_cnt_p0 <= '0;
    end else begin
      btn_s1_p0 <= bus.swap_btn_in;
      btn_s2_p0 <= btn_s1_p0;
      if (btn_s2_p0 != btn_db_p0) begin
        if (db_cnt_p0 == DB_LAST) begin
          btn_db_p0 <= btn_s2_p0;
          db_cnt_p0 <= '0;
        end else begin
          db_cnt_p0 <= db_cnt_p0 + DBW'(1);
        end
      end else begin
        db_cnt_p0 <= '0;
      end
    end
  end

  state_t              state_p0, state_nxt;
  logic [CW-1:0]       x_p0, y_p0;
  logic [ADDR_LEN-1:0] addr_p0;
  logic [1:0]          pattern_p0;
  logic [IDX_W-1:0]    front_p0, back_p0;
  logic                pending_p0;
  logic                fill_c, swap_c, clr_pend_c;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_p0 <= S_FILL;
    else            state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      S_FILL:  if (x_p0 == X_LAST && y_p0 == Y_LAST) state_nxt = S_READY;
      S_READY: if (pending_p0) state_nxt = S_WAIT;
      S_WAIT:  if (bus.frame_start_in) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    fill_c     = (state_p0 == S_FILL);
    swap_c     = (state_p0 == S_WAIT) && bus.frame_start_in;
    clr_pend_c = (state_p0 == S_READY) && pending_p0;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      x_p0       <= '0;
      y_p0       <= '0;
      addr_p0    <= '0;
      pattern_p0 <= 2'd0;
      front_p0   <= '0;
      back_p0    <= IDX_W'(1);
      pending_p0 <= 1'b0;
    end else begin
      if (fill_c) begin
        addr_p0 <= addr_p0 + ADDR_LEN'(1);
        if (x_p0 == X_LAST) begin
          x_p0 <= '0;
          y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + CW'(1);
        end else begin
          x_p0 <= x_p0 + CW'(1);
        end
      end
      if (swap_c) begin
        front_p0   <= back_p0;
        back_p0    <= (back_p0 == B_LAST) ? '0 : back_p0 + IDX_W'(1);
        pattern_p0 <= pattern_p0 + 2'd1;
        x_p0       <= '0;
        y_p0       <= '0;
        addr_p0    <= '0;
      end
      // A rise arriving while the request is being consumed is dropped.
      if (clr_pend_c)   pending_p0 <= 1'b0;
      else if (db_rise) pending_p0 <= 1'b1;
    end
  end

  // ---- stage p1: registered BRAM write, swap pulse and heartbeat ----
  logic                vld_p1, swap_p1, hb_p1;
  logic [ADDR_LEN-1:0] addr_p1;
  logic [WIDTH-1:0]    data_p1;
  logic [HEARTBEAT_BITS-1:0] hb_cnt_p0;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      vld_p1  <= 1'b0;
      swap_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= fill_c;
      swap_p1 <= swap_c;
      if (fill_c) begin
        addr_p1 <= addr_p0;
        data_p1 <= pattern_pix(pattern_p0, x_p0[WIDTH-1:0], y_p0[WIDTH-1:0], x_p0[3], y_p0[3]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hb_cnt_p0 <= '0;
      hb_p1     <= 1'b0;
    end else begin
      hb_cnt_p0 <= hb_cnt_p0 + HEARTBEAT_BITS'(1);
      if (hb_cnt_p0 == '0) hb_p1 <= ~hb_p1;
    end
  end

  assign bus.write_enable_out = vld_p1;
  assign bus.fill_busy_out    = vld_p1;
  assign bus.write_addr_out   = addr_p1;
  assign bus.write_data_out   = data_p1;
  assign bus.swap_buffers_out = swap_p1;
  assign bus.front_idx_out    = front_p0;
  assign bus.back_idx_out     = back_p0;
  assign bus.pattern_out      = pattern_p0;
  assign bus.heartbeat_out    = hb_p1;
endmodule

// File: tb/tb_fb_swap_pattern_ctrl.sv
// Bench for fb_swap_pattern_ctrl: directed scenarios plus random button/vsync traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_fb_swap_pattern_ctrl;
  localparam int W     = 4;
  localparam int DW    = 20;
  localparam int DH    = 6;
  localparam int AL    = 7;
  localparam int NB    = 3;
  localparam int DB    = 16;
  localparam int HB    = 5;
  localparam int DEPTH = DW * DH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_swap_pattern_ctrl_if #(.WIDTH(W), .ADDR_LEN(AL), .NUM_BUFFERS(NB)) bus ();

  fb_swap_pattern_ctrl #(
    .WIDTH(W), .DISPLAY_WIDTH(DW), .DISPLAY_HEIGHT(DH), .ADDR_LEN(AL),
    .NUM_BUFFERS(NB), .DEBOUNCE_CYCLES(DB), .HEARTBEAT_BITS(HB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_pix(input int sel, input int x, input int y);
    int m;
    m = 1 << W;
    case (sel)
      0:       return x % m;
      1:       return y % m;
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? m - 1 : 0;
      default: return (x + y) % m;
    endcase
  endfunction

  // Behavioural model: phase 0=filling, 1=idle, 2=waiting for vsync.
  int   m_phase = 0, m_k = 0, m_pat = 0, m_front = 0, m_back = 1, m_n = 0, m_run = 0;
  bit   m_pend = 0, m_s1 = 0, m_s2 = 0, m_db = 0;
  bit [1:0] m_rs = 2'b00;
  int   e_addr = 0, e_data = 0;
  bit   e_we = 0, e_swap = 0, e_hb = 0;

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_pat = 0; m_front = 0; m_back = 1; m_n = 0; m_run = 0;
    m_pend = 0; m_s1 = 0; m_s2 = 0; m_db = 0;
    e_addr = 0; e_data = 0; e_we = 0; e_swap = 0; e_hb = 0;
  endtask

  task automatic model_step();
    bit rise, clr;
    rise = m_s2 && !m_db && (m_run == DB - 1);
    clr  = (m_phase == 1) && m_pend;
    if (m_s2 != m_db) begin
      if (m_run == DB - 1) begin m_db = m_s2; m_run = 0; end
      else m_run++;
    end else m_run = 0;
    m_s2 = m_s1;
    m_s1 = bus.swap_btn_in;
    e_we = 0;
    e_swap = 0;
    case (m_phase)
      0: begin
        e_we   = 1;
        e_addr = m_k;
        e_data = exp_pix(m_pat, m_k % DW, m_k / DW);
        m_k++;
        if (m_k == DEPTH) m_phase = 1;
      end
      1: if (m_pend) m_phase = 2;
      default: if (bus.frame_start_in) begin
        e_swap  = 1;
        m_front = m_back;
        m_back  = (m_back + 1) % NB;
        m_pat   = (m_pat + 1) % 4;
        m_k     = 0;
        m_phase = 0;
      end
    endcase
    if (clr) m_pend = 0;
    else if (rise) m_pend = 1;
    if (m_n % (1 << HB) == 0) e_hb = !e_hb;
    m_n++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rs = 2'b00;
      model_reset();
    end else begin
      if (m_rs[1]) model_step();
      m_rs = {m_rs[0], 1'b1};
    end
  end

  // Per-cycle compare plus literal pins on writes and swaps.
  int wr_cnt = 0, swap_cnt = 0;
  always @(negedge clk) begin
    chk("we",    int'(bus.write_enable_out), int'(e_we));
    chk("busy",  int'(bus.fill_busy_out),    int'(e_we));
    chk("swap",  int'(bus.swap_buffers_out), int'(e_swap));
    chk("front", int'(bus.front_idx_out),    m_front);
    chk("back",  int'(bus.back_idx_out),     m_back);
    chk("pat",   int'(bus.pattern_out),      m_pat);
    chk("hb",    int'(bus.heartbeat_out),    int'(e_hb));
    chk("front_ne_back", int'(bus.front_idx_out != bus.back_idx_out), 1);
    if (e_we) begin
      chk("addr", int'(bus.write_addr_out), e_addr);
      chk("data", int'(bus.write_data_out), e_data);
    end
    if (bus.write_enable_out) begin
      wr_cnt++;
      if (bus.write_addr_out == 7'd5   && bus.pattern_out == 2'd0) chk("lit_p0_a5",   int'(bus.write_data_out), 5);
      if (bus.write_addr_out == 7'd25  && bus.pattern_out == 2'd1) chk("lit_p1_a25",  int'(bus.write_data_out), 1);
      if (bus.write_addr_out == 7'd8   && bus.pattern_out == 2'd2) chk("lit_p2_a8",   int'(bus.write_data_out), 15);
      if (bus.write_addr_out == 7'd119 && bus.pattern_out == 2'd3) chk("lit_p3_a119", int'(bus.write_data_out), 8);
    end
    if (bus.swap_buffers_out) begin
      swap_cnt++;
      chk("lit_swap_front", int'(bus.front_idx_out), swap_cnt % 3);
      chk("lit_swap_back",  int'(bus.back_idx_out),  (swap_cnt + 1) % 3);
      chk("lit_swap_pat",   int'(bus.pattern_out),   swap_cnt % 4);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph, input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      if (m_phase == ph) break;
      @(negedge clk);
    end
    if (i == limit) chk(name, m_phase, ph);
  endtask

  task automatic pulse_fs();
    bus.frame_start_in = 1'b1;
    cyc(1);
    bus.frame_start_in = 1'b0;
  endtask

  task automatic press(input int hi, input int lo);
    bus.swap_btn_in = 1'b1;
    cyc(hi);
    bus.swap_btn_in = 1'b0;
    cyc(lo);
  endtask

  initial begin
    int s0, hold;
    bus.swap_btn_in    = 1'b0;
    bus.frame_start_in = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_we",   int'(bus.write_enable_out), 0);
    chk("rst_back", int'(bus.back_idx_out), 1);
    chk("rst_pat",  int'(bus.pattern_out), 0);
    rst_n = 1'b1;

    // Initial fill with pattern 0, no swap.
    wait_phase(1, 400, "fill0_timeout");
    cyc(3);
    chk("fill0_writes", wr_cnt, DEPTH);
    chk("fill0_busy_fell", int'(bus.fill_busy_out), 0);
    chk("fill0_no_swap", swap_cnt, 0);

    // frame_start with nothing pending is ignored.
    pulse_fs();
    cyc(5);
    chk("idle_fs_no_swap", swap_cnt, 0);

    // Debounced press in READY, vsync 100 cycles later.
    press(DB + 10, 0);
    cyc(100);
    chk("press_waiting", m_phase, 2);
    wr_cnt = 0;
    pulse_fs();
    cyc(1);
    chk("swap1_count", swap_cnt, 1);

    // Two presses during the fill queue exactly one swap.
    press(DB + 2, DB + 2);
    press(DB + 2, DB + 2);
    wait_phase(2, 400, "queued_timeout");
    chk("fill1_writes", wr_cnt, DEPTH);
    pulse_fs();
    wait_phase(1, 400, "fill2_timeout");
    cyc(10);
    pulse_fs();
    cyc(10);
    chk("two_presses_one_swap", swap_cnt, 2);

    // Glitch shorter than the debounce window.
    s0 = swap_cnt;
    press(5, 40);
    chk("glitch_no_pend", int'(m_pend), 0);
    pulse_fs();
    cyc(5);
    chk("glitch_no_swap", swap_cnt, s0);

    // Third swap, then reset in the middle of the next fill.
    press(DB + 10, 10);
    pulse_fs();
    cyc(1);
    chk("swap3_count", swap_cnt, 3);
    wait_phase(0, 50, "fill3_start_timeout");
    while (m_k < 50 && m_phase == 0) cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we",    int'(bus.write_enable_out), 0);
    chk("async_rst_front", int'(bus.front_idx_out), 0);
    chk("async_rst_back",  int'(bus.back_idx_out), 1);
    chk("async_rst_pat",   int'(bus.pattern_out), 0);
    chk("async_rst_hb",    int'(bus.heartbeat_out), 0);
    cyc(2);
    swap_cnt = 0;
    #2 rst_n = 1'b1;
    begin
      int i;
      for (i = 0; i < 20 && !bus.write_enable_out; i++) cyc(1);
      chk("restart_seen", int'(bus.write_enable_out), 1);
      chk("restart_addr", int'(bus.write_addr_out), 0);
      chk("restart_pat",  int'(bus.pattern_out), 0);
    end

    // Random button and vsync traffic.
    for (int r = 0; r < 200; r++) begin
      hold = $urandom_range(1, 40);
      bus.swap_btn_in = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < hold; c++) begin
        bus.frame_start_in = ($urandom_range(0, 24) == 0);
        cyc(1);
      end
    end
    bus.frame_start_in = 1'b0;
    bus.swap_btn_in    = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
